// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: operand forwarding, load-use stalls, branch flush,
// start-up enable sequencing and halt detection for the in-order core.
// A FWD_DEPTH-deep scoreboard mirrors the instructions that have left
// decode. Each entry carries the number of cycles left before its result
// can be forwarded.
//
// This block is sequenced entirely by counters, so it has no state-machine table.
module pipe_hazard_ctrl #(
    parameter int unsigned FWD_DEPTH   = 3,
    parameter int unsigned RA_W        = 5,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_SLOTS = 2,
    parameter int unsigned START_DELAY = 2,
    parameter logic [31:0] HALT_INST   = 32'hffffffff,
    parameter int unsigned SEL_W       = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_dec_valid,
    input  logic [31:0]      i_dec_inst,
    input  logic [RA_W-1:0]  i_dec_sa,
    input  logic [RA_W-1:0]  i_dec_sb,
    input  logic             i_dec_use_a,
    input  logic             i_dec_use_b,
    input  logic [RA_W-1:0]  i_dec_dr,
    input  logic             i_dec_rw,
    input  logic             i_dec_is_load,
    input  logic             i_br_taken,
    output logic [SEL_W-1:0] o_fwd_sel_a,
    output logic [SEL_W-1:0] o_fwd_sel_b,
    output logic             o_stall,
    output logic             o_flush,
    output logic             o_pipe_en,
    output logic             o_halt
);

    localparam int unsigned RDY_W  = $clog2(FWD_DEPTH + 1);
    localparam int unsigned FCNT_W = $clog2(FLUSH_SLOTS + 1);
    localparam int unsigned SCNT_W = $clog2(START_DELAY + 2);
    localparam int unsigned HCNT_W = $clog2(FWD_DEPTH + 2);

    localparam logic [RDY_W-1:0]  LOAD_RDY     = RDY_W'(LOAD_LAT);
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_SLOTS - 1);
    localparam logic [SCNT_W-1:0] START_CNT    = SCNT_W'(START_DELAY);
    localparam logic [HCNT_W-1:0] HALT_RUN     = HCNT_W'(FWD_DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic             rw;
        logic [RA_W-1:0]  dr;
        logic [RDY_W-1:0] rdy;
    } sb_entry_t;

    sb_entry_t [FWD_DEPTH-1:0] r_sb;
    sb_entry_t [FWD_DEPTH-1:0] w_sb_nxt;

    logic [SCNT_W-1:0] r_start_cnt;
    logic [SCNT_W-1:0] w_start_cnt_nxt;
    logic              r_pipe_en;
    logic [HCNT_W-1:0] r_halt_cnt;
    logic [HCNT_W-1:0] w_halt_cnt_nxt;
    logic              r_halt;
    logic              w_halt_nxt;
    logic [FCNT_W-1:0] r_flush_cnt;
    logic [FCNT_W-1:0] w_flush_cnt_nxt;

    logic             w_qual_a;
    logic             w_qual_b;
    logic             w_haz_a;
    logic             w_haz_b;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_flush;
    logic             w_stall;
    logic             w_issue;
    logic             w_halt_entry;

    // The youngest matching writer decides the outcome. If that writer is
    // not ready yet, an older ready copy of the register is stale and must
    // not be forwarded. Result is {hazard, sel}.
    function automatic logic [SEL_W:0] lookup(
        input logic                      qual,
        input logic [RA_W-1:0]           src,
        input sb_entry_t [FWD_DEPTH-1:0] sb
    );
        logic           hit;
        logic [SEL_W:0] res;
        hit = 1'b0;
        res = '0;
        for (int i = 0; i < int'(FWD_DEPTH); i++) begin
            if (qual && !hit && sb[i].valid && sb[i].rw && (sb[i].dr == src)) begin
                hit = 1'b1;
                if (sb[i].rdy == '0) begin
                    res = {1'b0, SEL_W'(i + 1)};
                end else begin
                    res = {1'b1, {SEL_W{1'b0}}};
                end
            end
        end
        return res;
    endfunction

    // Decode inputs count as bubbles until the pipe is enabled.
    assign w_qual_a = r_pipe_en & i_dec_valid & i_dec_use_a & (i_dec_sa != '0);
    assign w_qual_b = r_pipe_en & i_dec_valid & i_dec_use_b & (i_dec_sb != '0);

    assign {w_haz_a, w_sel_a} = lookup(w_qual_a, i_dec_sa, r_sb);
    assign {w_haz_b, w_sel_b} = lookup(w_qual_b, i_dec_sb, r_sb);

    // A taken branch squashes the instruction in decode, so any hazard it has is irrelevant.
    assign w_flush = i_br_taken | (r_flush_cnt != '0);
    assign w_stall = (w_haz_a | w_haz_b) & ~w_flush;
    assign w_issue = i_dec_valid & r_pipe_en & ~w_stall & ~w_flush;

    assign w_halt_entry = w_issue & (i_dec_inst == HALT_INST);

    // Next scoreboard: entry 0 takes the issued instruction or a bubble, older entries age by one slot.
    always_comb begin
        w_sb_nxt = '0;
        if (w_issue) begin
            w_sb_nxt[0].valid = 1'b1;
            w_sb_nxt[0].rw    = i_dec_rw;
            w_sb_nxt[0].dr    = i_dec_dr;
            w_sb_nxt[0].rdy   = i_dec_is_load ? LOAD_RDY : '0;
        end
        for (int i = 1; i < int'(FWD_DEPTH); i++) begin
            w_sb_nxt[i] = r_sb[i-1];
            if (r_sb[i-1].rdy != '0) begin
                w_sb_nxt[i].rdy = r_sb[i-1].rdy - RDY_W'(1);
            end
        end
    end

    // Next values of the start-up, halt-run and flush counters.
    always_comb begin
        w_start_cnt_nxt = (r_start_cnt == START_CNT) ? r_start_cnt : r_start_cnt + SCNT_W'(1);

        w_halt_cnt_nxt = '0;
        if (w_halt_entry) begin
            w_halt_cnt_nxt = (r_halt_cnt == HALT_RUN) ? r_halt_cnt : r_halt_cnt + HCNT_W'(1);
        end
        w_halt_nxt = r_halt | (w_halt_cnt_nxt == HALT_RUN);

        w_flush_cnt_nxt = r_flush_cnt;
        if (i_br_taken) begin
            w_flush_cnt_nxt = FLUSH_RELOAD;
        end else if (r_flush_cnt != '0) begin
            w_flush_cnt_nxt = r_flush_cnt - FCNT_W'(1);
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_nxt;
        end
    end

    // Counters plus registered enable and halt; halt takes the pipe down on the same edge it sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_cnt <= '0;
            r_pipe_en   <= 1'b0;
            r_halt_cnt  <= '0;
            r_halt      <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_start_cnt <= w_start_cnt_nxt;
            r_pipe_en   <= (w_start_cnt_nxt == START_CNT) & ~w_halt_nxt;
            r_halt_cnt  <= w_halt_cnt_nxt;
            r_halt      <= w_halt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    assign o_fwd_sel_a = w_sel_a;
    assign o_fwd_sel_b = w_sel_b;
    assign o_stall     = w_stall;
    assign o_flush     = w_flush;
    assign o_pipe_en   = r_pipe_en;
    assign o_halt      = r_halt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenario tasks followed by a randomized
// run against a history-based reference model.
module tb_pipe_hazard_ctrl;

    localparam int          FWD_DEPTH   = 3;
    localparam int          RA_W        = 5;
    localparam int          LOAD_LAT    = 1;
    localparam int          FLUSH_SLOTS = 2;
    localparam int          START_DELAY = 2;
    localparam logic [31:0] HALT_INST   = 32'hffffffff;
    localparam logic [31:0] NOP_INST    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_dec_valid;
    logic [31:0] i_dec_inst;
    logic [4:0]  i_dec_sa, i_dec_sb, i_dec_dr;
    logic        i_dec_use_a, i_dec_use_b, i_dec_rw, i_dec_is_load, i_br_taken;
    logic [1:0]  o_fwd_sel_a, o_fwd_sel_b;
    logic        o_stall, o_flush, o_pipe_en, o_halt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FWD_DEPTH  (FWD_DEPTH),
        .RA_W       (RA_W),
        .LOAD_LAT   (LOAD_LAT),
        .FLUSH_SLOTS(FLUSH_SLOTS),
        .START_DELAY(START_DELAY),
        .HALT_INST  (HALT_INST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_dec_valid  (i_dec_valid),
        .i_dec_inst   (i_dec_inst),
        .i_dec_sa     (i_dec_sa),
        .i_dec_sb     (i_dec_sb),
        .i_dec_use_a  (i_dec_use_a),
        .i_dec_use_b  (i_dec_use_b),
        .i_dec_dr     (i_dec_dr),
        .i_dec_rw     (i_dec_rw),
        .i_dec_is_load(i_dec_is_load),
        .i_br_taken   (i_br_taken),
        .o_fwd_sel_a  (o_fwd_sel_a),
        .o_fwd_sel_b  (o_fwd_sel_b),
        .o_stall      (o_stall),
        .o_flush      (o_flush),
        .o_pipe_en    (o_pipe_en),
        .o_halt       (o_halt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst,
                         input logic [4:0] sa, input logic ua,
                         input logic [4:0] sb, input logic ub,
                         input logic [4:0] dr, input logic rw,
                         input logic ld, input logic br);
        i_dec_valid = v;  i_dec_inst = inst;
        i_dec_sa = sa;    i_dec_use_a = ua;
        i_dec_sb = sb;    i_dec_use_b = ub;
        i_dec_dr = dr;    i_dec_rw = rw;
        i_dec_is_load = ld; i_br_taken = br;
    endtask

    task automatic bubble();
        drive(1'b0, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bubble();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (START_DELAY) tick();
    endtask

    task automatic test_reset();
        bubble();
        rst_n = 1'b0;
        #3;
        checks++; if (o_pipe_en !== 1'b0) begin failures++; $display("FAIL reset_pipe_en got=%b want=0", o_pipe_en); end
        checks++; if (o_halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b want=0", o_halt); end
        checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", o_stall); end
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b want=0", o_flush); end
        checks++; if (o_fwd_sel_a !== 2'd0 || o_fwd_sel_b !== 2'd0) begin failures++; $display("FAIL reset_fwd_sel got=%0d/%0d want=0/0", o_fwd_sel_a, o_fwd_sel_b); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++; if (o_pipe_en !== 1'b0) begin failures++; $display("FAIL startup_edge1 got=%b want=0", o_pipe_en); end
        tick();
        checks++; if (o_pipe_en !== 1'b1) begin failures++; $display("FAIL startup_edge2 got=%b want=1", o_pipe_en); end
    endtask

    task automatic test_forward_distance();
        logic [1:0] exp_sel;
        do_reset();
        for (int k = 0; k <= FWD_DEPTH; k++) begin
            drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
            tick();
            repeat (k) begin
                drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
                tick();
            end
            drive(1'b1, NOP_INST, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
            #1;
            exp_sel = (k < FWD_DEPTH) ? 2'(k + 1) : 2'd0;
            checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL fwd_dist_stall k=%0d got=%b want=0", k, o_stall); end
            checks++; if (o_fwd_sel_a !== exp_sel) begin failures++; $display("FAIL fwd_dist_sel_a k=%0d got=%0d want=%0d", k, o_fwd_sel_a, exp_sel); end
            checks++; if (o_fwd_sel_b !== exp_sel) begin failures++; $display("FAIL fwd_dist_sel_b k=%0d got=%0d want=%0d", k, o_fwd_sel_b, exp_sel); end
            tick();
        end
        bubble();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%b want=1", o_stall); end
        tick();
        checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL load_use_release got=%b want=0", o_stall); end
        checks++; if (o_fwd_sel_b !== 2'd2) begin failures++; $display("FAIL load_use_sel_b got=%0d want=2", o_fwd_sel_b); end
        tick();
        bubble();
    endtask

    task automatic test_r0_youngest();
        do_reset();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b want=0", o_stall); end
        checks++; if (o_fwd_sel_a !== 2'd0 || o_fwd_sel_b !== 2'd0) begin failures++; $display("FAIL r0_fwd got=%0d/%0d want=0/0", o_fwd_sel_a, o_fwd_sel_b); end
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, NOP_INST, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (o_fwd_sel_a !== 2'd1) begin failures++; $display("FAIL youngest_alu got=%0d want=1", o_fwd_sel_a); end
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL youngest_load_stall got=%b want=1", o_stall); end
        tick();
        checks++; if (o_stall !== 1'b0 || o_fwd_sel_b !== 2'd2) begin failures++; $display("FAIL youngest_load_fwd got=stall%b/sel%0d want=stall0/sel2", o_stall, o_fwd_sel_b); end
        tick();
        bubble();
    endtask

    task automatic test_flush_hazard();
        do_reset();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        #1;
        checks++; if (o_flush !== 1'b1 || o_stall !== 1'b0) begin failures++; $display("FAIL flush_cyc1 got=flush%b/stall%b want=flush1/stall0", o_flush, o_stall); end
        tick();
        i_br_taken = 1'b0;
        #1;
        checks++; if (o_flush !== 1'b1 || o_stall !== 1'b0) begin failures++; $display("FAIL flush_cyc2 got=flush%b/stall%b want=flush1/stall0", o_flush, o_stall); end
        tick();
        drive(1'b1, NOP_INST, 5'd9, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL flush_end got=%b want=0", o_flush); end
        checks++; if (o_fwd_sel_a !== 2'd0 || o_fwd_sel_b !== 2'd3) begin failures++; $display("FAIL flush_bubbles got=%0d/%0d want=0/3", o_fwd_sel_a, o_fwd_sel_b); end
        tick();
        bubble();
    endtask

    task automatic test_halt();
        do_reset();
        drive(1'b1, HALT_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, HALT_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (FWD_DEPTH) tick();
        checks++; if (o_halt !== 1'b0 || o_pipe_en !== 1'b1) begin failures++; $display("FAIL halt_count_reset got=halt%b/en%b want=halt0/en1", o_halt, o_pipe_en); end
        tick();
        checks++; if (o_halt !== 1'b1 || o_pipe_en !== 1'b0) begin failures++; $display("FAIL halt_set got=halt%b/en%b want=halt1/en0", o_halt, o_pipe_en); end
        bubble();
        repeat (3) tick();
        checks++; if (o_halt !== 1'b1 || o_pipe_en !== 1'b0) begin failures++; $display("FAIL halt_sticky got=halt%b/en%b want=halt1/en0", o_halt, o_pipe_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_halt !== 1'b0) begin failures++; $display("FAIL halt_async_clear got=%b want=0", o_halt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_async_reset_stall();
        do_reset();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, NOP_INST, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL async_pre_stall got=%b want=1", o_stall); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_stall !== 1'b0 || o_pipe_en !== 1'b0 || o_halt !== 1'b0) begin failures++; $display("FAIL async_clear got=stall%b/en%b/halt%b want=0/0/0", o_stall, o_pipe_en, o_halt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (START_DELAY) tick();
        checks++; if (o_pipe_en !== 1'b1 || o_stall !== 1'b0 || o_fwd_sel_b !== 2'd0) begin failures++; $display("FAIL async_sb_cleared got=en%b/stall%b/sel%0d want=1/0/0", o_pipe_en, o_stall, o_fwd_sel_b); end
        bubble();
        tick();
    endtask

    // Reference model: the last FWD_DEPTH issue slots as a history list. A
    // load in slot i is forwardable once it has spent LOAD_LAT cycles in
    // flight, i.e. when i >= LOAD_LAT.
    bit       m_v  [FWD_DEPTH];
    bit       m_rw [FWD_DEPTH];
    bit       m_ld [FWD_DEPTH];
    bit [4:0] m_dr [FWD_DEPTH];

    function automatic int find_writer(input bit qual, input bit [4:0] src);
        if (!qual) return -1;
        for (int i = 0; i < FWD_DEPTH; i++)
            if (m_v[i] && m_rw[i] && m_dr[i] == src) return i;
        return -1;
    endfunction

    task automatic test_random();
        int  edges, halt_run, flush_left, ia, ib;
        bit  m_halt, en, ha, hb, e_flush, e_stall, issue;
        bit [1:0] e_sa, e_sb;
        do_reset();
        for (int i = 0; i < FWD_DEPTH; i++) begin m_v[i] = 0; m_rw[i] = 0; m_ld[i] = 0; m_dr[i] = 0; end
        edges = START_DELAY; halt_run = 0; flush_left = 0; m_halt = 0;
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 9) == 0) ? HALT_INST : $urandom,
                  5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            #1;
            en = (edges >= START_DELAY) && !m_halt;
            ia = find_writer(en && i_dec_valid && i_dec_use_a && i_dec_sa != 0, i_dec_sa);
            ib = find_writer(en && i_dec_valid && i_dec_use_b && i_dec_sb != 0, i_dec_sb);
            ha = (ia >= 0) && m_ld[ia] && (ia < LOAD_LAT);
            hb = (ib >= 0) && m_ld[ib] && (ib < LOAD_LAT);
            e_sa = (ia >= 0 && !ha) ? 2'(ia + 1) : 2'd0;
            e_sb = (ib >= 0 && !hb) ? 2'(ib + 1) : 2'd0;
            e_flush = i_br_taken || (flush_left > 0);
            e_stall = (ha || hb) && !e_flush;
            checks++; if (o_pipe_en !== en) begin failures++; $display("FAIL rand_pipe_en c=%0d got=%b want=%b", c, o_pipe_en, en); end
            checks++; if (o_halt !== m_halt) begin failures++; $display("FAIL rand_halt c=%0d got=%b want=%b", c, o_halt, m_halt); end
            checks++; if (o_flush !== e_flush) begin failures++; $display("FAIL rand_flush c=%0d got=%b want=%b", c, o_flush, e_flush); end
            checks++; if (o_stall !== e_stall) begin failures++; $display("FAIL rand_stall c=%0d got=%b want=%b", c, o_stall, e_stall); end
            if (!e_stall) begin
                checks++; if (o_fwd_sel_a !== e_sa) begin failures++; $display("FAIL rand_sel_a c=%0d got=%0d want=%0d", c, o_fwd_sel_a, e_sa); end
                checks++; if (o_fwd_sel_b !== e_sb) begin failures++; $display("FAIL rand_sel_b c=%0d got=%0d want=%0d", c, o_fwd_sel_b, e_sb); end
            end
            issue = i_dec_valid && en && !e_stall && !e_flush;
            for (int i = FWD_DEPTH - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_rw[i] = m_rw[i-1]; m_ld[i] = m_ld[i-1]; m_dr[i] = m_dr[i-1];
            end
            m_v[0] = issue; m_rw[0] = i_dec_rw; m_ld[0] = i_dec_is_load; m_dr[0] = i_dec_dr;
            halt_run = (issue && i_dec_inst == HALT_INST) ? halt_run + 1 : 0;
            if (halt_run >= FWD_DEPTH + 1) m_halt = 1;
            edges++;
            flush_left = i_br_taken ? FLUSH_SLOTS - 1 : ((flush_left > 0) ? flush_left - 1 : 0);
            tick();
        end
        bubble();
    endtask

    initial begin
        bubble();
        test_reset();
        test_forward_distance();
        test_load_use();
        test_r0_youngest();
        test_flush_hazard();
        test_halt();
        test_async_reset_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control unit for the next-generation in-order RISC core. It replaces fixed single-stage forwarding and stalling with a scoreboard of FWD_DEPTH downstream stages and handles:
- per-operand forwarding selection;
- load-use stalls for multi-cycle results;
- multi-slot branch flush;
- start-up enable sequencing;
- halt detection.

It sits beside the decode/operand-fetch stage and drives the operand muxes and the pipeline-register enables and clears.

Parameters:
FWD_DEPTH, 3, number of downstream stages tracked; entry 0 is EX.
RA_W, 5, register address width; register 0 is hard-wired zero.
LOAD_LAT, 1, extra cycles before a load result is forwardable; range 0..FWD_DEPTH-1.
FLUSH_SLOTS, 2, number of younger instructions squashed on a taken branch; minimum 1.
START_DELAY, 2, cycles after reset release before pipe_en rises.
HALT_INST, 32'hffffffff, halt instruction encoding.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode stage holds a real instruction
dec_inst  in  32  decode-stage instruction word
dec_sa  in  RA_W  source A register
dec_sb  in  RA_W  source B register
dec_use_a  in  1  source A is read from the register file
dec_use_b  in  1  source B is read from the register file
dec_dr  in  RA_W  destination register
dec_rw  in  1  instruction writes dr
dec_is_load  in  1  instruction is a load
br_taken  in  1  EX-stage branch or jump taken this cycle
fwd_sel_a  out  $clog2(FWD_DEPTH+1)  0 = register file, k = result of scoreboard entry k-1
fwd_sel_b  out  $clog2(FWD_DEPTH+1)  as fwd_sel_a, for source B
stall  out  1  hold IF and DOF and insert a bubble into EX
flush  out  1  clear IF/DOF pipeline registers
pipe_en  out  1  pipeline running
halt  out  1  sticky halt

Behaviour:
- Reset (async, rst_n=0): scoreboard entries invalid; all counters 0; pipe_en=0, halt=0, stall=0, flush=0, fwd_sel_a=fwd_sel_b=0.
- Start-up: a counter increments each clk after reset release. pipe_en rises on the START_DELAY-th edge. While pipe_en=0, the decode inputs are treated as bubbles.
- Scoreboard: FWD_DEPTH entries, each holding {valid, dr, rw, rdy_cnt}.
  - Every clk, entry i moves to entry i+1; the last entry drops off.
  - rdy_cnt decrements as it shifts, saturating at 0.
  - Entry 0 loads the decode instruction when dec_valid & pipe_en & ~stall & ~flush. Otherwise entry 0 loads a bubble (valid=0).
  - rdy_cnt loads LOAD_LAT for loads and 0 for everything else.
- Forwarding (combinational from the current scoreboard):
  - An operand qualifies when use=1, its register is != 0, and dec_valid=1.
  - Search for the youngest (lowest i) entry with valid & rw & dr == src.
  - No match: sel=0.
  - Match with rdy_cnt=0: sel=i+1.
  - Match with rdy_cnt>0: hazard.
  - An older matching entry is never chosen over a younger one.
- Stall: stall = (hazard_a | hazard_b) & ~flush. fwd_sel is don't-care while stall=1.
- Flush:
  - br_taken loads the flush counter with FLUSH_SLOTS-1.
  - flush = br_taken | (counter != 0); the counter decrements each cycle while nonzero.
  - A second br_taken during a flush reloads the counter.
  - br_taken together with a hazard: flush wins, stall=0.
- Halt:
  - A counter increments on each cycle where an instruction equal to HALT_INST enters entry 0.
  - It clears on any other entry, including bubbles.
  - halt is registered and is set when the count reaches FWD_DEPTH+1.
  - halt is sticky until reset. Once halt=1, pipe_en drops to 0.
- All outputs except fwd_sel_a, fwd_sel_b, stall and flush are registered.

Test Plan:
- Reset release with START_DELAY=2 -> pipe_en=0 after the 1st edge and 1 after the 2nd; all outputs 0 during reset.
- Back-to-back ALU ops: r3 written, then the next instruction reads sa=3 -> fwd_sel_a=1, stall=0. After one unrelated instruction in between -> fwd_sel_a=2. After FWD_DEPTH intervening instructions -> 0.
- Load r5 with LOAD_LAT=1, next instruction reads sb=5 -> stall=1 for exactly 1 cycle with a bubble in entry 0, then fwd_sel_b=2.
- r0 as destination and source -> never forwarded and never stalls. Two in-flight writers of r7 -> the youngest wins (fwd_sel=1 over 2).
- br_taken with FLUSH_SLOTS=2 coinciding with a load-use hazard -> flush high 2 cycles, stall=0, entry 0 bubbles both cycles.
- Feed 32'hffffffff continuously -> halt=1 after FWD_DEPTH+1 entries and pipe_en=0; a non-halt instruction inserted mid-sequence resets the count. Async reset mid-stall clears halt, the scoreboard and stall immediately.
